cond_logic_fp: RTL

Conditional-execution and flag stage sitting directly downstream of the instruction decoder in the single-cycle ARM datapath. It holds the NZCV flag registers and evaluates each instruction's condition field. It gates the decoder's PCS/RegW/MemW into architectural write enables. For FP-class instructions it runs a start/done handshake with an iterative FP unit, stalling the PC until the result is written back or a watchdog expires.

---
 rtl/cond_logic_fp.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/cond_logic_fp.sv
// cond_logic_fp: NZCV flag register, condition evaluation and write-enable
// gating for the single-cycle ARM datapath, plus a start/done handshake with
// an iterative FP unit that stalls the PC until writeback or watchdog abort.
`timescale 1ns/1ps

module cond_logic_fp #(
    parameter int FP_TIMEOUT = 64
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] Cond,
    input  logic [3:0] ALUFlags,
    input  logic [3:0] FPFlags,
    input  logic [1:0] FlagW,
    input  logic       PCS,
    input  logic       RegW,
    input  logic       MemW,
    input  logic       FP,
    input  logic       FPDone,
    output logic       PCSrc,
    output logic       RegWrite,
    output logic       MemWrite,
    output logic       FPStart,
    output logic       Stall,
    output logic [3:0] Flags,
    output logic       FPTimeout
);

    localparam int CNT_W = (FP_TIMEOUT > 2) ? $clog2(FP_TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FP_TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_WB   = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [3:0]       flags_q, flags_d;
    logic             timeout_q, timeout_d;
    logic [3:0]       fpflags_q;
    logic             cond_ex;

    // ARM condition-code evaluation against {N,Z,C,V}.
    function automatic logic cond_eval(input logic [3:0] c, input logic [3:0] f);
        logic n, z, cy, v;
        n  = f[3];
        z  = f[2];
        cy = f[1];
        v  = f[0];
        case (c)
            4'b0000: cond_eval = z;
            4'b0001: cond_eval = ~z;
            4'b0010: cond_eval = cy;
            4'b0011: cond_eval = ~cy;
            4'b0100: cond_eval = n;
            4'b0101: cond_eval = ~n;
            4'b0110: cond_eval = v;
            4'b0111: cond_eval = ~v;
            4'b1000: cond_eval = cy & ~z;
            4'b1001: cond_eval = ~cy | z;
            4'b1010: cond_eval = (n == v);
            4'b1011: cond_eval = (n != v);
            4'b1100: cond_eval = ~z & (n == v);
            4'b1101: cond_eval = z | (n != v);
            4'b1110: cond_eval = 1'b1;
            default: cond_eval = 1'b0;
        endcase
    endfunction

    // Merge new flags into the current ones: fw[1] selects NZ, fw[0] selects CV.
    function automatic logic [3:0] apply_flags(input logic [3:0] cur,
                                               input logic [3:0] src,
                                               input logic [1:0] fw);
        logic [3:0] res;
        res = cur;
        if (fw[1]) res[3:2] = src[3:2];
        if (fw[0]) res[1:0] = src[1:0];
        return res;
    endfunction

    assign cond_ex = cond_eval(Cond, flags_q);

    // Control state: FSM, watchdog counter, architectural flags, sticky abort.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            flags_q   <= 4'b0000;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            flags_q   <= flags_d;
            timeout_q <= timeout_d;
        end
    end

    // FP result flags captured on the done pulse, consumed in the writeback cycle.
    always_ff @(posedge clk) begin
        if (state_q == S_BUSY && FPDone) begin
            fpflags_q <= FPFlags;
        end
    end

    // Next-state logic and gated enables; the condition is only evaluated in IDLE
    // because flags cannot change while the FP unit is busy.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        flags_d   = flags_q;
        timeout_d = timeout_q;
        PCSrc     = 1'b0;
        RegWrite  = 1'b0;
        MemWrite  = 1'b0;
        FPStart   = 1'b0;
        Stall     = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (!FP) begin
                    PCSrc    = PCS  & cond_ex;
                    RegWrite = RegW & cond_ex;
                    MemWrite = MemW & cond_ex;
                    flags_d  = apply_flags(flags_q, ALUFlags, FlagW & {2{cond_ex}});
                end else if (cond_ex) begin
                    // Start pulse is suppressed while reset is held low.
                    FPStart = reset;
                    Stall   = 1'b1;
                    cnt_d   = '0;
                    state_d = S_BUSY;
                end
            end
            S_BUSY: begin
                Stall = 1'b1;
                cnt_d = cnt_q + CNT_W'(1);
                if (FPDone) begin
                    state_d = S_WB;
                end else if (cnt_q == CNT_LAST) begin
                    timeout_d = 1'b1;
                    state_d   = S_IDLE;
                end
            end
            S_WB: begin
                PCSrc    = PCS;
                RegWrite = RegW;
                flags_d  = apply_flags(flags_q, fpflags_q, FlagW);
                state_d  = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign Flags     = flags_q;
    assign FPTimeout = timeout_q;

endmodule
